// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU sharing arbiter: opcode encodings, overflow /
// underflow flag encodings and the arbiter state enum.
// -----------------------------------------------------------------------------
package fpu_pkg;

   // FPU opcodes
   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;   // x - y
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_CMP = 2'd3;

   // Overflow / underflow flag encodings
   localparam logic [1:0] OFUF_OK = 2'b00;
   localparam logic [1:0] OFUF_OV = 2'b10;
   localparam logic [1:0] OFUF_UF = 2'b01;

   // Arbiter sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arbState_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches req starting at bit ptr
// upward with wrap-around and reports the first set bit.
//   req        in  N_REQ  request vector
//   ptr        in  IDX_W  highest-priority index this round (must be < N_REQ)
//   gnt_onehot out N_REQ  one-hot winner (0 when no request)
//   gnt_idx    out IDX_W  binary winner index (0 when no request)
//   any        out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_pick
   import fpu_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any
);

   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   // Walk candidates ptr, ptr+1, ... (mod N_REQ); the first requester seen wins.
   always_comb begin
      int               cand;
      logic             hit;
      logic [N_REQ-1:0] rot;
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      cand       = 0;
      hit        = 1'b0;
      rot        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand       = (int'(ptr) + k) % N_REQ;
         rot        = req >> cand;
         hit        = rot[0] & ~any;
         gnt_onehot = hit ? (ONE << cand) : gnt_onehot;
         gnt_idx    = hit ? IDX_W'(cand) : gnt_idx;
         any        = any | rot[0];
      end
   end

endmodule

// File: rtl/fpu_share_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_share_arbiter
// Shares one fpu_16bit among N_REQ requesters. Grants round-robin, latches the
// winner's operands, pulses the FPU start pin, waits for fpu_done (guarded by a
// watchdog) and returns the result only to the granted requester.
//   clk, reset              clock, asynchronous active-high reset
//   req_valid/x/y/op        per-requester request and operand slices
//   req_ready               one-hot accept pulse (visible in the ISSUE cycle)
//   rsp_valid               one-hot response pulse (RESP cycle)
//   rsp_result/ofuf/cmp     response data, stable until the next RESP
//   rsp_timeout             operation aborted by watchdog
//   busy                    arbiter not in IDLE
//   fpu_x/y/op/start        FPU operand and start drive
//   fpu_done/result/ofuf/cmp FPU completion and results
// -----------------------------------------------------------------------------
module fpu_share_arbiter
   import fpu_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int IDX_W          = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [16*N_REQ-1:0]   req_x,
   input  logic [16*N_REQ-1:0]   req_y,
   input  logic [2*N_REQ-1:0]    req_op,
   output logic [N_REQ-1:0]      req_ready,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [15:0]           rsp_result,
   output logic [1:0]            rsp_ofuf,
   output logic [2:0]            rsp_cmp,
   output logic                  rsp_timeout,
   output logic                  busy,
   output logic [15:0]           fpu_x,
   output logic [15:0]           fpu_y,
   output logic [1:0]            fpu_op,
   output logic                  fpu_start,
   input  logic                  fpu_done,
   input  logic [15:0]           fpu_result,
   input  logic [1:0]            fpu_ofuf,
   input  logic [2:0]            fpu_cmp
);

   // Last watchdog value before abort: WAIT lasts at most TIMEOUT_CYCLES cycles.
   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

   arbState_t          state;
   logic [IDX_W-1:0]   rrPtr;
   logic [N_REQ-1:0]   grantOnehot;
   logic [15:0]        wdogCnt;
   logic [N_REQ-1:0]   pickOnehot;
   logic [IDX_W-1:0]   pickIdx;
   logic               pickAny;
   logic [16*N_REQ-1:0] shX;
   logic [16*N_REQ-1:0] shY;
   logic [2*N_REQ-1:0]  shOp;
   logic [15:0]        selX;
   logic [15:0]        selY;
   logic [1:0]         selOp;
   logic [IDX_W-1:0]   nextPtr;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) uPick (
      .req        (req_valid),
      .ptr        (rrPtr),
      .gnt_onehot (pickOnehot),
      .gnt_idx    (pickIdx),
      .any        (pickAny)
   );

   // Select the winning requester's operand slices.
   always_comb begin
      shX   = req_x >> {pickIdx, 4'b0000};
      shY   = req_y >> {pickIdx, 4'b0000};
      shOp  = req_op >> {pickIdx, 1'b0};
      selX  = shX[15:0];
      selY  = shY[15:0];
      selOp = shOp[1:0];
   end

   // Pointer one past the winner, wrapping at N_REQ (which need not be a power of 2).
   always_comb begin
      if (pickIdx == IDX_W'(N_REQ - 1)) begin
         nextPtr = '0;
      end else begin
         nextPtr = pickIdx + IDX_W'(1);
      end
   end

   // Arbiter FSM with registered outputs; pulses default low every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         rrPtr       <= '0;
         grantOnehot <= '0;
         wdogCnt     <= 16'd0;
         req_ready   <= '0;
         rsp_valid   <= '0;
         rsp_result  <= 16'd0;
         rsp_ofuf    <= OFUF_OK;
         rsp_cmp     <= 3'd0;
         rsp_timeout <= 1'b0;
         busy        <= 1'b0;
         fpu_x       <= 16'd0;
         fpu_y       <= 16'd0;
         fpu_op      <= 2'd0;
         fpu_start   <= 1'b0;
      end else begin
         req_ready <= '0;
         rsp_valid <= '0;
         fpu_start <= 1'b0;
         case (state)
            IDLE: begin
               if (pickAny) begin
                  // Accept and start are registered, so both show in the ISSUE cycle.
                  req_ready   <= pickOnehot;
                  grantOnehot <= pickOnehot;
                  fpu_x       <= selX;
                  fpu_y       <= selY;
                  fpu_op      <= selOp;
                  rrPtr       <= nextPtr;
                  fpu_start   <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ISSUE;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            ISSUE: begin
               // fpu_done here is left over from the previous operation.
               wdogCnt <= 16'd0;
               state   <= WAIT;
            end
            WAIT: begin
               if (fpu_done) begin
                  // Completion takes priority over a simultaneous watchdog expiry.
                  rsp_result  <= fpu_result;
                  rsp_ofuf    <= fpu_ofuf;
                  rsp_cmp     <= fpu_cmp;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= grantOnehot;
                  state       <= RESP;
               end else if (wdogCnt == WDOG_LAST) begin
                  rsp_result  <= 16'd0;
                  rsp_ofuf    <= OFUF_OK;
                  rsp_cmp     <= 3'd0;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= grantOnehot;
                  state       <= RESP;
               end else begin
                  wdogCnt <= wdogCnt + 16'd1;
                  state   <= WAIT;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
